// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin sync, clock glitch filter, 11-bit deserialiser.
// Optional macro PS2_RX_BREAK_FILTER_EN drops break-code (F0 xx) key-release bytes.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_clk,
    input  logic       PS2_dat,
    output logic [7:0] data,
    output logic       valid,
    output logic       err_parity,
    output logic       err_frame,
    output logic       busy
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_lvl, filt_lvl_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          parity_ok;
    logic          stop_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_lvl   <= 1'b1;
            filt_lvl_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            filt_lvl_d <= filt_lvl;
            if (clk_s2 == filt_lvl) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_lvl <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_lvl_d & ~filt_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (fall || state == S_IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires on the cycle the counter would reach TIMEOUT_CYCLES; error is visible the next cycle.
    assign timeout   = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign parity_ok = ^{shreg, par_bit};
    assign stop_ok   = dat_s2;
    assign busy      = (state != S_IDLE);

`ifdef PS2_RX_BREAK_FILTER_EN
    logic break_pending;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data       <= 8'h00;
            valid      <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
`ifdef PS2_RX_BREAK_FILTER_EN
            break_pending <= 1'b0;
`endif
        end else begin
            valid      <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg[bit_cnt] <= dat_s2;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                        if (!stop_ok || !parity_ok) begin
                            err_frame  <= !stop_ok;
                            err_parity <= !parity_ok;
`ifdef PS2_RX_BREAK_FILTER_EN
                            break_pending <= 1'b0;
`endif
                        end else begin
`ifdef PS2_RX_BREAK_FILTER_EN
                            // F0 arms the filter; the byte after it is the released key.
                            if (break_pending) begin
                                break_pending <= 1'b0;
                            end else if (shreg == 8'hF0) begin
                                break_pending <= 1'b1;
                            end else begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end
`else
                            data  <= shreg;
                            valid <= 1'b1;
`endif
                        end
                    end
                endcase
            end else if (timeout) begin
                state     <= S_IDLE;
                err_frame <= 1'b1;
`ifdef PS2_RX_BREAK_FILTER_EN
                break_pending <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed frames, timeout, glitches, resets, random frames.
// Expectations come from a frame-level model; build with PS2_RX_BREAK_FILTER_EN to check the filter.
module tb_ps2_frame_rx;

    localparam int FL = 8;
    localparam int TO = 300;
    localparam int H  = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] data;
    logic       valid, err_parity, err_frame, busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0;
    int v_cyc = 0, e_cyc = 0, f_cyc = 0;
    int stop_fall_cyc = 0;
    logic [7:0] m_data = 8'h00;
    bit m_bp = 1'b0;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .PS2_clk(ps2_clk), .PS2_dat(ps2_dat),
        .data(data), .valid(valid), .err_parity(err_parity),
        .err_frame(err_frame), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin n_valid <= n_valid + 1; v_cyc <= cyc; end
            if (err_parity) begin n_perr <= n_perr + 1; e_cyc <= cyc; end
            if (err_frame) begin n_ferr <= n_ferr + 1; e_cyc <= cyc; f_cyc <= cyc; end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit cell: data set while clock high, then the falling edge the host samples on.
    task automatic ps2_bit(input bit b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            tick(20); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(H - 23);
        end else begin
            tick(H);
        end
        ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit pflip, input bit stopv, input int gl);
        ps2_bit(1'b0, gl == 0);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(b[i], gl == i + 1);
            if (i == 0) check("busy_mid", busy, 1);
        end
        ps2_bit((~^b) ^ pflip, gl == 9);
        ps2_bit(stopv, gl == 10);
        ps2_dat = 1'b1;
    endtask

    // Frame-level reference: outcome from the byte, parity flip and stop bit alone.
    task automatic model(input logic [7:0] b, input bit pflip, input bit stopv,
                         output bit ev, output bit ep, output bit ef);
        bit ones_odd;
        ones_odd = ^b;
        ef = !stopv;
        ep = pflip;
        ev = stopv && !pflip;
        if (ones_odd && !pflip) ep = 1'b0;
`ifdef PS2_RX_BREAK_FILTER_EN
        if (ep || ef) m_bp = 1'b0;
        else if (m_bp) begin m_bp = 1'b0; ev = 1'b0; end
        else if (b == 8'hF0) begin m_bp = 1'b1; ev = 1'b0; end
`endif
        if (ev) m_data = b;
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input bit pflip,
                         input bit stopv, input int gl);
        int v0, p0, f0;
        bit ev, ep, ef;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        model(b, pflip, stopv, ev, ep, ef);
        send(b, pflip, stopv, gl);
        tick(20);
        check({tag, "_valid"}, n_valid - v0, int'(ev));
        check({tag, "_perr"}, n_perr - p0, int'(ep));
        check({tag, "_ferr"}, n_ferr - f0, int'(ef));
        check({tag, "_data"}, data, m_data);
        check({tag, "_busy"}, busy, 0);
        if (ev) check({tag, "_vlat"}, v_cyc - stop_fall_cyc, FL + 3);
        if (ep || ef) check({tag, "_elat"}, e_cyc - stop_fall_cyc, FL + 3);
    endtask

    initial begin
        int v0, p0, f0, w, last;
        logic [7:0] rb;
        int r;
        #1 reset = 1'b1;
        tick(5);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_perr", err_parity, 0);
        check("rst_ferr", err_frame, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick(5);

        // Short low glitch while idle
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(30);
        check("idle_glitch_pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        check("idle_glitch_busy", busy, 0);

        frame("good1c", 8'h1C, 1'b0, 1'b1, -1);
        frame("par1c", 8'h1C, 1'b1, 1'b1, -1);
        frame("stop5a", 8'h5A, 1'b0, 1'b0, -1);
        frame("good16", 8'h16, 1'b0, 1'b1, -1);

        // Abandoned frame: start + 3 data bits, then clock parked high
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0);
        last = stop_fall_cyc;
        ps2_dat = 1'b1;
        w = 0;
        while (n_ferr == f0 && w < TO + 200) begin tick(1); w++; end
        tick(2);
        check("to_seen", n_ferr - f0, 1);
        check("to_lat", f_cyc - last, FL + 3 + TO);
        check("to_busy", busy, 0);
        check("to_valid", n_valid - v0, 0);
        check("to_perr", n_perr - p0, 0);
        m_bp = 1'b0;
        frame("good45", 8'h45, 1'b0, 1'b1, -1);

        frame("glitch1c", 8'h1C, 1'b0, 1'b1, 4);

        v0 = n_valid;
        frame("seq1", 8'h1C, 1'b0, 1'b1, -1);
        frame("seqf0", 8'hF0, 1'b0, 1'b1, -1);
        frame("seq2", 8'h1C, 1'b0, 1'b1, -1);
        frame("seqe0", 8'hE0, 1'b0, 1'b1, -1);
`ifdef PS2_RX_BREAK_FILTER_EN
        check("seq_count", n_valid - v0, 2);
`else
        check("seq_count", n_valid - v0, 4);
`endif

        // Reset in the middle of a frame
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0);
        reset = 1'b1; tick(2); reset = 1'b0; ps2_dat = 1'b1;
        tick(TO + 50);
        check("rstmid_pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_data", data, 0);
        m_data = 8'h00; m_bp = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom);
            r = int'($urandom_range(0, 7));
            if (r == 2) rb = 8'hF0;
            if (r == 3) rb = 8'hE0;
            frame("rand", rb, r == 0, r != 1, int'($urandom_range(0, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
